// File: rtl/rat_ckpt.sv
// rat_ckpt: multi-lane register alias table with circular checkpoint storage.
//
// Renames up to NUM_LANES destinations per cycle in program order (lane 0 oldest).
// It serves NUM_READ_PORTS source lookups and reports the prior mapping of every
// renamed destination. It holds up to NUM_CKPTS age-ordered snapshots so that a
// mispredict can roll the table back in a single cycle.
//
// Ports
//   CLK          in   rising-edge clock
//   RESET        in   synchronous active-low reset (identity mapping, empty buffer)
//   Write        in   per-lane rename enable
//   Write_arch   in   per-lane architectural destination (lane k at [k*LA +: LA])
//   Write_phys   in   per-lane new physical destination  (lane k at [k*LP +: LP])
//   Prev_phys    out  per-lane prior mapping of Write_arch, seen through older lanes
//   Read_arch    in   source lookup addresses
//   Read_phys    out  source lookup results
//   Ckpt_take    in   snapshot request (the branch records Ckpt_id of that cycle)
//   Ckpt_id      out  slot the next take will use (tail pointer)
//   Ckpt_full    out  all snapshot slots occupied
//   Ckpt_release in   free the oldest checkpoint
//   Restore      in   roll back to checkpoint Restore_id
//   Restore_id   in   checkpoint to restore
//   RegPtrs      out  live table, entry i at [i*LP +: LP]
//
// Build option
//   RAT_BYPASS_EN  when defined, Read_phys forwards same-cycle renames (write-through),
//                  except in a cycle with a valid restore.
//
// Arch addresses at or above NUM_ARCH_REGS read as 0 and are never written.

module rat_ckpt #(
  parameter int unsigned NUM_ARCH_REGS  = 35,
  parameter int unsigned NUM_PHYS_REGS  = 64,
  parameter int unsigned NUM_LANES      = 2,
  parameter int unsigned NUM_READ_PORTS = 4,
  parameter int unsigned NUM_CKPTS      = 4,
  localparam int unsigned LA = $clog2(NUM_ARCH_REGS),
  localparam int unsigned LP = $clog2(NUM_PHYS_REGS),
  localparam int unsigned LC = $clog2(NUM_CKPTS)
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_LANES-1:0]          Write,
  input  logic [NUM_LANES*LA-1:0]       Write_arch,
  input  logic [NUM_LANES*LP-1:0]       Write_phys,
  output logic [NUM_LANES*LP-1:0]       Prev_phys,
  input  logic [NUM_READ_PORTS*LA-1:0]  Read_arch,
  output logic [NUM_READ_PORTS*LP-1:0]  Read_phys,
  input  logic                          Ckpt_take,
  output logic [LC-1:0]                 Ckpt_id,
  output logic                          Ckpt_full,
  input  logic                          Ckpt_release,
  input  logic                          Restore,
  input  logic [LC-1:0]                 Restore_id,
  output logic [NUM_ARCH_REGS*LP-1:0]   RegPtrs
);

  localparam int unsigned CW = LC + 1;

  function automatic logic arch_ok(input logic [LA-1:0] a);
    return 32'(a) < NUM_ARCH_REGS;
  endfunction

  // Live table and snapshot storage
  logic [LP-1:0] rat_q   [NUM_ARCH_REGS];
  logic [LP-1:0] rat_d   [NUM_ARCH_REGS];
  logic [LP-1:0] rat_ren [NUM_ARCH_REGS];
  logic [LP-1:0] snap_q  [NUM_CKPTS][NUM_ARCH_REGS];

  // Circular buffer bookkeeping: head = oldest live, tail = next free slot
  logic [LC-1:0] head_q, head_d;
  logic [LC-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Unpacked views of the flat lane/port buses
  logic [LA-1:0] w_arch [NUM_LANES];
  logic [LP-1:0] w_phys [NUM_LANES];
  logic [LA-1:0] r_arch [NUM_READ_PORTS];

  logic          full;
  logic [LC-1:0] rst_dist;
  logic          restore_ok;
  logic          take_ok;
  logic          release_ok;

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      w_arch[l] = Write_arch[l*LA +: LA];
      w_phys[l] = Write_phys[l*LP +: LP];
    end
    for (int r = 0; r < NUM_READ_PORTS; r++) begin
      r_arch[r] = Read_arch[r*LA +: LA];
    end
  end

  // ---------------------------------------------------------------------------
  // Checkpoint control
  // ---------------------------------------------------------------------------

  assign full     = (count_q == CW'(NUM_CKPTS));
  // Distance from the oldest checkpoint; Restore_id is live exactly when it is below count.
  assign rst_dist = Restore_id - head_q;

  always_comb begin
    restore_ok = Restore && ({1'b0, rst_dist} < count_q);
    take_ok    = Ckpt_take && !full && !restore_ok;
    // Restoring the oldest checkpoint leaves nothing older to release.
    release_ok = Ckpt_release && (count_q != '0) && (!restore_ok || (rst_dist != '0));
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (restore_ok) begin
      tail_d  = Restore_id;
      count_d = {1'b0, rst_dist};
      if (release_ok) begin
        head_d  = head_q + LC'(1);
        count_d = {1'b0, rst_dist} - CW'(1);
      end
    end else begin
      if (take_ok) begin
        tail_d  = tail_q + LC'(1);
      end
      if (release_ok) begin
        head_d  = head_q + LC'(1);
      end
      case ({take_ok, release_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Rename datapath
  // ---------------------------------------------------------------------------

  // Table after this cycle's renames; later lanes overwrite earlier ones.
  always_comb begin
    for (int i = 0; i < NUM_ARCH_REGS; i++) begin
      rat_ren[i] = rat_q[i];
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      if (Write[l] && arch_ok(w_arch[l])) begin
        rat_ren[w_arch[l]] = w_phys[l];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ARCH_REGS; i++) begin
      rat_d[i] = restore_ok ? snap_q[Restore_id][i] : rat_ren[i];
    end
  end

  // Prior mapping: registered value, overridden by the youngest older lane that
  // writes the same arch reg in this cycle.
  always_comb begin
    Prev_phys = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      logic [LP-1:0] prev;
      prev = '0;
      if (arch_ok(w_arch[k])) begin
        prev = rat_q[w_arch[k]];
      end
      for (int j = 0; j < k; j++) begin
        if (Write[j] && (w_arch[j] == w_arch[k])) begin
          prev = w_phys[j];
        end
      end
      Prev_phys[k*LP +: LP] = prev;
    end
  end

  always_comb begin
    Read_phys = '0;
    for (int r = 0; r < NUM_READ_PORTS; r++) begin
      logic [LP-1:0] val;
      val = '0;
      if (arch_ok(r_arch[r])) begin
        val = rat_q[r_arch[r]];
      end
`ifdef RAT_BYPASS_EN
      if (!restore_ok) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (Write[l] && (w_arch[l] == r_arch[r])) begin
            val = w_phys[l];
          end
        end
      end
`endif
      Read_phys[r*LP +: LP] = val;
    end
  end

  always_comb begin
    RegPtrs = '0;
    for (int i = 0; i < NUM_ARCH_REGS; i++) begin
      RegPtrs[i*LP +: LP] = rat_q[i];
    end
  end

  assign Ckpt_id   = tail_q;
  assign Ckpt_full = full;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
        rat_q[i] <= LP'(i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      rat_q   <= rat_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Snapshot contents need no reset; a slot is only read once a take has filled it.
  always_ff @(posedge CLK) begin
    if (RESET && take_ok) begin
      snap_q[tail_q] <= rat_ren;
    end
  end

endmodule

// File: tb/tb_rat_ckpt.sv
module tb_rat_ckpt;

  localparam int NA = 35;
  localparam int NL = 2;
  localparam int NR = 4;
  localparam int NC = 4;

  logic            CLK;
  logic            RESET;
  logic [NL-1:0]   Write;
  logic [NL*6-1:0] Write_arch;
  logic [NL*6-1:0] Write_phys;
  logic [NL*6-1:0] Prev_phys;
  logic [NR*6-1:0] Read_arch;
  logic [NR*6-1:0] Read_phys;
  logic            Ckpt_take;
  logic [1:0]      Ckpt_id;
  logic            Ckpt_full;
  logic            Ckpt_release;
  logic            Restore;
  logic [1:0]      Restore_id;
  logic [NA*6-1:0] RegPtrs;

  rat_ckpt dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .Write        (Write),
    .Write_arch   (Write_arch),
    .Write_phys   (Write_phys),
    .Prev_phys    (Prev_phys),
    .Read_arch    (Read_arch),
    .Read_phys    (Read_phys),
    .Ckpt_take    (Ckpt_take),
    .Ckpt_id      (Ckpt_id),
    .Ckpt_full    (Ckpt_full),
    .Ckpt_release (Ckpt_release),
    .Restore      (Restore),
    .Restore_id   (Restore_id),
    .RegPtrs      (RegPtrs)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // Stimulus variables
  int w_en[NL], w_arch[NL], w_phys[NL], r_arch[NR];
  int take, rel, rst, rst_id;

  // Reference model: table, snapshots by id, and the ordered list of live ids
  int m_tbl[NA];
  int m_snap[NC][NA];
  int m_live[$];
  int m_tail;
  int e_prev[NL], e_read[NR], e_id;
  int e_full;

  function automatic int regptr(int i);
    return int'(RegPtrs[i*6 +: 6]);
  endfunction
  function automatic int prevp(int k);
    return int'(Prev_phys[k*6 +: 6]);
  endfunction
  function automatic int readp(int r);
    return int'(Read_phys[r*6 +: 6]);
  endfunction

  function automatic int live_pos(int id);
    for (int i = 0; i < m_live.size(); i++) if (m_live[i] == id) return i;
    return -1;
  endfunction

  function automatic void model_comb();
    int rv;
    rv = (rst != 0) && (live_pos(rst_id) >= 0);
    for (int k = 0; k < NL; k++) begin
      int v;
      v = (w_arch[k] < NA) ? m_tbl[w_arch[k]] : 0;
      for (int j = 0; j < k; j++) if (w_en[j] != 0 && w_arch[j] == w_arch[k]) v = w_phys[j];
      e_prev[k] = v;
    end
    for (int r = 0; r < NR; r++) begin
      int v;
      v = (r_arch[r] < NA) ? m_tbl[r_arch[r]] : 0;
`ifdef RAT_BYPASS_EN
      if (!rv) for (int l = 0; l < NL; l++) if (w_en[l] != 0 && w_arch[l] == r_arch[r]) v = w_phys[l];
`endif
      e_read[r] = v;
    end
    e_id   = m_tail;
    e_full = (m_live.size() == NC);
  endfunction

  function automatic void model_update();
    int p, n0, tk, rl;
    if (RESET == 1'b0) begin
      for (int i = 0; i < NA; i++) m_tbl[i] = i;
      m_live.delete();
      m_tail = 0;
      return;
    end
    p = (rst != 0) ? live_pos(rst_id) : -1;
    if (p >= 0) begin
      while (m_live.size() > p) void'(m_live.pop_back());
      if (rel != 0 && p > 0) void'(m_live.pop_front());
      for (int i = 0; i < NA; i++) m_tbl[i] = m_snap[rst_id][i];
      m_tail = rst_id;
    end else begin
      n0 = m_live.size();
      tk = (take != 0) && (n0 < NC);
      rl = (rel != 0) && (n0 > 0);
      for (int l = 0; l < NL; l++) if (w_en[l] != 0 && w_arch[l] < NA) m_tbl[w_arch[l]] = w_phys[l];
      if (tk != 0) begin
        for (int i = 0; i < NA; i++) m_snap[m_tail][i] = m_tbl[i];
        m_live.push_back(m_tail);
        m_tail = (m_tail + 1) % NC;
      end
      if (rl != 0) void'(m_live.pop_front());
    end
  endfunction

  task automatic idle();
    for (int l = 0; l < NL; l++) begin w_en[l] = 0; w_arch[l] = 0; w_phys[l] = 0; end
    for (int r = 0; r < NR; r++) r_arch[r] = 0;
    take = 0; rel = 0; rst = 0; rst_id = 0;
  endtask

  task automatic drive();
    for (int l = 0; l < NL; l++) begin
      Write[l]             = (w_en[l] != 0);
      Write_arch[l*6 +: 6] = 6'(w_arch[l]);
      Write_phys[l*6 +: 6] = 6'(w_phys[l]);
    end
    for (int r = 0; r < NR; r++) Read_arch[r*6 +: 6] = 6'(r_arch[r]);
    Ckpt_take    = (take != 0);
    Ckpt_release = (rel != 0);
    Restore      = (rst != 0);
    Restore_id   = 2'(rst_id);
    #1;
  endtask

  task automatic clk_step();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    idle();
    RESET = 1'b0;
    drive();
    clk_step();
    RESET = 1'b1;
    drive();
  endtask

  task automatic take_cycle(input int arch, input int phys);
    idle();
    take = 1;
    if (arch >= 0) begin w_en[0] = 1; w_arch[0] = arch; w_phys[0] = phys; end
    drive();
    clk_step();
    idle();
    drive();
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    checks++; if (regptr(5) !== 5) begin errors++; $display("FAIL reset RegPtrs[5]: got %0d expected 5", regptr(5)); end
    checks++; if (regptr(34) !== 34) begin errors++; $display("FAIL reset RegPtrs[34]: got %0d expected 34", regptr(34)); end
    bad = 0;
    for (int i = 0; i < NA; i++) if (regptr(i) !== i) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL reset identity: got %0d wrong entries expected 0", bad); end
    checks++; if (Ckpt_full !== 1'b0) begin errors++; $display("FAIL reset Ckpt_full: got %0b expected 0", Ckpt_full); end
    checks++; if (Ckpt_id !== 2'd0) begin errors++; $display("FAIL reset Ckpt_id: got %0d expected 0", Ckpt_id); end
  endtask

  task automatic test_rename_same_reg();
    int exp_rd;
    do_reset();
    w_en[0] = 1; w_arch[0] = 3; w_phys[0] = 40;
    w_en[1] = 1; w_arch[1] = 3; w_phys[1] = 41;
    r_arch[0] = 3; r_arch[1] = 4;
    drive();
`ifdef RAT_BYPASS_EN
    exp_rd = 41;
`else
    exp_rd = 3;
`endif
    checks++; if (prevp(0) !== 3) begin errors++; $display("FAIL same_reg Prev_phys[0]: got %0d expected 3", prevp(0)); end
    checks++; if (prevp(1) !== 40) begin errors++; $display("FAIL same_reg Prev_phys[1]: got %0d expected 40", prevp(1)); end
    checks++; if (readp(0) !== exp_rd) begin errors++; $display("FAIL same_reg Read_phys[0]: got %0d expected %0d", readp(0), exp_rd); end
    checks++; if (readp(1) !== 4) begin errors++; $display("FAIL same_reg Read_phys[1]: got %0d expected 4", readp(1)); end
    clk_step();
    idle(); r_arch[2] = 3; drive();
    checks++; if (regptr(3) !== 41) begin errors++; $display("FAIL same_reg RegPtrs[3]: got %0d expected 41", regptr(3)); end
    checks++; if (readp(2) !== 41) begin errors++; $display("FAIL same_reg Read_phys[2] next: got %0d expected 41", readp(2)); end
  endtask

  task automatic test_ckpt_restore();
    do_reset();
    take = 1; w_en[0] = 1; w_arch[0] = 7; w_phys[0] = 50;
    drive();
    checks++; if (Ckpt_id !== 2'd0) begin errors++; $display("FAIL ckpt take id: got %0d expected 0", Ckpt_id); end
    clk_step();
    idle(); w_en[1] = 1; w_arch[1] = 7; w_phys[1] = 51; drive();
    checks++; if (Ckpt_id !== 2'd1) begin errors++; $display("FAIL ckpt tail after take: got %0d expected 1", Ckpt_id); end
    clk_step();
    idle(); drive();
    checks++; if (regptr(7) !== 51) begin errors++; $display("FAIL ckpt RegPtrs[7] pre-restore: got %0d expected 51", regptr(7)); end
    idle(); rst = 1; rst_id = 0; w_en[0] = 1; w_arch[0] = 9; w_phys[0] = 60; drive();
    clk_step();
    idle(); drive();
    checks++; if (regptr(7) !== 50) begin errors++; $display("FAIL ckpt restore RegPtrs[7]: got %0d expected 50", regptr(7)); end
    checks++; if (regptr(9) !== 9) begin errors++; $display("FAIL ckpt restore dropped rename: got %0d expected 9", regptr(9)); end
    checks++; if (Ckpt_id !== 2'd0) begin errors++; $display("FAIL ckpt restore Ckpt_id: got %0d expected 0", Ckpt_id); end
    // Buffer is now empty, so restoring id 0 again must be ignored and the rename kept.
    idle(); rst = 1; rst_id = 0; w_en[0] = 1; w_arch[0] = 7; w_phys[0] = 52; drive();
    clk_step();
    idle(); drive();
    checks++; if (regptr(7) !== 52) begin errors++; $display("FAIL ckpt empty restore RegPtrs[7]: got %0d expected 52", regptr(7)); end
  endtask

  task automatic test_full();
    do_reset();
    for (int n = 0; n < 4; n++) begin
      checks++; if (Ckpt_full !== 1'b0) begin errors++; $display("FAIL full early at take %0d: got %0b expected 0", n, Ckpt_full); end
      take_cycle(-1, 0);
    end
    checks++; if (Ckpt_full !== 1'b1) begin errors++; $display("FAIL full after 4 takes: got %0b expected 1", Ckpt_full); end
    checks++; if (Ckpt_id !== 2'd0) begin errors++; $display("FAIL full tail after 4 takes: got %0d expected 0", Ckpt_id); end
    take_cycle(-1, 0);
    checks++; if (Ckpt_id !== 2'd0) begin errors++; $display("FAIL full fifth take tail: got %0d expected 0", Ckpt_id); end
    checks++; if (Ckpt_full !== 1'b1) begin errors++; $display("FAIL full fifth take full: got %0b expected 1", Ckpt_full); end
    idle(); take = 1; rel = 1; drive();
    clk_step();
    idle(); drive();
    checks++; if (Ckpt_full !== 1'b0) begin errors++; $display("FAIL full take+release full: got %0b expected 0", Ckpt_full); end
    checks++; if (Ckpt_id !== 2'd0) begin errors++; $display("FAIL full take+release tail: got %0d expected 0", Ckpt_id); end
    take_cycle(-1, 0);
    checks++; if (Ckpt_full !== 1'b1 || Ckpt_id !== 2'd1) begin errors++;
      $display("FAIL full refill: got full=%0b id=%0d expected full=1 id=1", Ckpt_full, Ckpt_id); end
  endtask

  task automatic test_restore_release();
    do_reset();
    take_cycle(10, 20);
    take_cycle(10, 21);
    take_cycle(10, 22);
    idle(); rst = 1; rst_id = 2; rel = 1; drive();
    clk_step();
    idle(); drive();
    checks++; if (regptr(10) !== 22) begin errors++; $display("FAIL rr restore2 RegPtrs[10]: got %0d expected 22", regptr(10)); end
    checks++; if (Ckpt_id !== 2'd2) begin errors++; $display("FAIL rr restore2 tail: got %0d expected 2", Ckpt_id); end
    // head is now 1, so id 0 is stale and the rename goes through.
    idle(); rst = 1; rst_id = 0; w_en[0] = 1; w_arch[0] = 10; w_phys[0] = 30; drive();
    clk_step();
    idle(); drive();
    checks++; if (regptr(10) !== 30) begin errors++; $display("FAIL rr stale id0 RegPtrs[10]: got %0d expected 30", regptr(10)); end
    idle(); rst = 1; rst_id = 1; drive();
    clk_step();
    idle(); drive();
    checks++; if (regptr(10) !== 21 || Ckpt_id !== 2'd1) begin errors++;
      $display("FAIL rr restore1: got reg=%0d id=%0d expected reg=21 id=1", regptr(10), Ckpt_id); end

    do_reset();
    take_cycle(11, 25);
    take_cycle(11, 26);
    idle(); rst = 1; rst_id = 0; rel = 1; drive();
    clk_step();
    idle(); drive();
    checks++; if (regptr(11) !== 25 || Ckpt_id !== 2'd0) begin errors++;
      $display("FAIL rr restore0+release: got reg=%0d id=%0d expected reg=25 id=0", regptr(11), Ckpt_id); end
    for (int n = 0; n < 3; n++) take_cycle(-1, 0);
    checks++; if (Ckpt_full !== 1'b0) begin errors++; $display("FAIL rr count after 3 takes: full=%0b expected 0", Ckpt_full); end
    take_cycle(-1, 0);
    checks++; if (Ckpt_full !== 1'b1) begin errors++; $display("FAIL rr count after 4 takes: full=%0b expected 1", Ckpt_full); end
  endtask

  task automatic test_invalid_restore();
    do_reset();
    take_cycle(-1, 0);
    take_cycle(-1, 0);
    idle(); rst = 1; rst_id = 3; w_en[0] = 1; w_arch[0] = 12; w_phys[0] = 33; drive();
    checks++; if (prevp(0) !== 12) begin errors++; $display("FAIL invalid Prev_phys[0]: got %0d expected 12", prevp(0)); end
    clk_step();
    idle(); drive();
    checks++; if (regptr(12) !== 33) begin errors++; $display("FAIL invalid RegPtrs[12]: got %0d expected 33", regptr(12)); end
    checks++; if (Ckpt_id !== 2'd2) begin errors++; $display("FAIL invalid tail: got %0d expected 2", Ckpt_id); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 500; n++) begin
      int bad, first;
      idle();
      for (int l = 0; l < NL; l++) begin
        w_en[l]   = $urandom_range(0, 1);
        w_arch[l] = $urandom_range(0, NA - 1);
        w_phys[l] = $urandom_range(0, 63);
      end
      if ($urandom_range(0, 3) == 0) w_arch[1] = w_arch[0];
      for (int r = 0; r < NR; r++)
        r_arch[r] = ($urandom_range(0, 2) == 0) ? w_arch[$urandom_range(0, 1)] : $urandom_range(0, NA - 1);
      take   = ($urandom_range(0, 9) < 4);
      rel    = ($urandom_range(0, 9) < 3);
      rst    = ($urandom_range(0, 9) == 0);
      rst_id = (m_live.size() > 0 && $urandom_range(0, 3) != 0)
               ? m_live[$urandom_range(0, m_live.size() - 1)] : $urandom_range(0, NC - 1);
      drive();
      model_comb();
      for (int k = 0; k < NL; k++) begin
        checks++; if (prevp(k) !== e_prev[k]) begin errors++;
          $display("FAIL rand cyc %0d Prev_phys[%0d]: got %0d expected %0d", n, k, prevp(k), e_prev[k]); end
      end
      for (int r = 0; r < NR; r++) begin
        checks++; if (readp(r) !== e_read[r]) begin errors++;
          $display("FAIL rand cyc %0d Read_phys[%0d]: got %0d expected %0d", n, r, readp(r), e_read[r]); end
      end
      checks++; if (int'(Ckpt_id) !== e_id) begin errors++;
        $display("FAIL rand cyc %0d Ckpt_id: got %0d expected %0d", n, Ckpt_id, e_id); end
      checks++; if (int'(Ckpt_full) !== e_full) begin errors++;
        $display("FAIL rand cyc %0d Ckpt_full: got %0d expected %0d", n, Ckpt_full, e_full); end
      clk_step();
      bad = 0; first = -1;
      for (int i = 0; i < NA; i++) if (regptr(i) !== m_tbl[i]) begin bad++; if (first < 0) first = i; end
      checks++; if (bad != 0) begin errors++;
        $display("FAIL rand cyc %0d RegPtrs[%0d]: got %0d expected %0d (%0d entries differ)",
                 n, first, regptr(first), m_tbl[first], bad); end
    end
  endtask

  initial begin
    RESET = 1'b0;
    idle();
    drive();
    test_reset();
    test_rename_same_reg();
    test_ckpt_restore();
    test_full();
    test_restore_release();
    test_invalid_restore();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
